// File: rtl/time_pkg.sv
// Shared field widths, moduli and field types for the time-of-day counter.
//   SEC_W / MIN_W     : bit widths of the seconds and minutes fields
//   SEC_MOD / MIN_MOD : moduli of the seconds and minutes fields
package time_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;

    typedef logic [SEC_W-1:0] sec_t;
    typedef logic [MIN_W-1:0] min_t;

endpackage

// File: rtl/counter_mod_n_en.sv
// Enabled modulo-n counter with synchronous load, used as one field of the
// time-of-day counter. Fields are chained by feeding carry into the next en.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, clears value
//   en       : count enable (increment by one per edge)
//   load     : synchronous load, takes priority over en
//   load_val : value taken on a load edge
//   n        : modulus (one bit wider than value so n = 2**W is expressible)
//   value    : registered count, 0..n-1
//   carry    : combinational, high when en is set and value is n-1
module counter_mod_n_en #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W:0]   n,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] r_value;
    logic         w_at_max;

    // Compare against the modulus rather than relying on width overflow.
    assign w_at_max = ({1'b0, r_value} == (n - 1'b1));
    assign carry    = en && w_at_max;
    assign value    = r_value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (en) begin
            r_value <= w_at_max ? '0 : r_value + 1'b1;
        end
    end

endmodule

// File: rtl/time_counter_hms.sv
// Time-of-day counter (hours:minutes:seconds) advanced by the one-cycle
// rollover pulse of an upstream prescaler. Supports pause, synchronous time
// set with per-field range substitution, and a registered day-rollover pulse.
//   i_clk       : clock, rising edge
//   i_reset_n   : asynchronous active-low reset, clears all outputs
//   i_tick      : seconds enable pulse
//   i_run       : 1 = count on i_tick, 0 = hold
//   i_load      : synchronous load of all fields (tick in same cycle dropped)
//   i_load_sec  : seconds load value (>59 loads as 0)
//   i_load_min  : minutes load value (>59 loads as 0)
//   i_load_hour : hours load value (>HOURS-1 loads as 0)
//   o_sec/o_min/o_hour : current time fields
//   o_day_ro    : one-cycle pulse after HOURS-1:59:59 -> 0:00:00
module time_counter_hms
    import time_pkg::*;
#(
    parameter int unsigned HOURS  = 24,
    parameter int unsigned HOUR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_tick,
    input  logic              i_run,
    input  logic              i_load,
    input  logic [5:0]        i_load_sec,
    input  logic [5:0]        i_load_min,
    input  logic [HOUR_W-1:0] i_load_hour,
    output logic [5:0]        o_sec,
    output logic [5:0]        o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_day_ro
);

    localparam logic [SEC_W:0]  SEC_N  = (SEC_W + 1)'(SEC_MOD);
    localparam logic [MIN_W:0]  MIN_N  = (MIN_W + 1)'(MIN_MOD);
    localparam logic [HOUR_W:0] HOUR_N = (HOUR_W + 1)'(HOURS);

    sec_t              w_sec_ld;
    min_t              w_min_ld;
    logic [HOUR_W-1:0] w_hour_ld;
    logic              w_sec_en;
    logic              w_sec_carry;
    logic              w_min_carry;
    logic              w_hour_carry;
    logic              r_day_ro;

    // Each out-of-range field is replaced by zero independently.
    assign w_sec_ld  = ({1'b0, i_load_sec}  < SEC_N)  ? i_load_sec  : '0;
    assign w_min_ld  = ({1'b0, i_load_min}  < MIN_N)  ? i_load_min  : '0;
    assign w_hour_ld = ({1'b0, i_load_hour} < HOUR_N) ? i_load_hour : '0;

    // Gating with ~i_load also keeps the carry chain (and day pulse) quiet
    // on a load edge.
    assign w_sec_en = i_run && i_tick && !i_load;

    counter_mod_n_en #(.W(SEC_W)) u_sec (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .en       (w_sec_en),
        .load     (i_load),
        .load_val (w_sec_ld),
        .n        (SEC_N),
        .value    (o_sec),
        .carry    (w_sec_carry)
    );

    counter_mod_n_en #(.W(MIN_W)) u_min (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .en       (w_sec_carry),
        .load     (i_load),
        .load_val (w_min_ld),
        .n        (MIN_N),
        .value    (o_min),
        .carry    (w_min_carry)
    );

    counter_mod_n_en #(.W(HOUR_W)) u_hour (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .en       (w_min_carry),
        .load     (i_load),
        .load_val (w_hour_ld),
        .n        (HOUR_N),
        .value    (o_hour),
        .carry    (w_hour_carry)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_day_ro <= 1'b0;
        end else begin
            r_day_ro <= w_hour_carry;
        end
    end

    assign o_day_ro = r_day_ro;

endmodule
